lane_rr_arbiter: RTL

- Round-robin arbiter sharing one registered output lane (one DFF stage per data bit) between NREQ requesters.
- Sits between the IB-driven input lanes and a single OB-driven output lane in the testarch feature designs.
- Exercises arbitration logic (LUTs) feeding the shared flip-flop stage.
- Supports bounded burst ownership so one requester cannot starve the others.

---
 rtl/lane_rr_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/lane_rr_arbiter.sv
// Round-robin arbiter sharing one registered output lane between NREQ requesters.
// An owner keeps the lane until it drops its request, or until it has held the lane
// for MAX_BURST consecutive cycles while someone else is waiting.
module lane_rr_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DATA_W    = 1,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] data,
  output logic [NREQ-1:0]        gnt,
  output logic [2:0]             owner,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data
);

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e            state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [2:0]        owner_q, owner_d;
  logic [3:0]        burst_q, burst_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              own_req;
  logic [DATA_W-1:0] own_data;
  logic [NREQ-1:0]   others;
  logic [2:0]        nxt;

  // First set bit of r, scanning circularly upward from index start.
  function automatic logic [2:0] scan_from(input logic [NREQ-1:0] r, input logic [2:0] start);
    logic [2*NREQ-1:0] rot;
    logic [3:0]        sum;
    logic [2:0]        pick;
    rot  = {r, r} >> start;
    pick = '0;
    sum  = '0;
    // Descending loop so the smallest offset is the last (winning) assignment.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = {1'b0, start} + 4'(i);
        if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
        pick = sum[2:0];
      end
    end
    return pick;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [2:0] k);
    logic [NREQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (k == 3'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // Request level and data word of the current owner; other requesters' data is ignored.
  always_comb begin
    own_req  = 1'b0;
    own_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == 3'(i)) begin
        own_req  = req[i];
        own_data = data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign others = req & ~gnt_q;
  assign nxt    = (owner_q == 3'(NREQ - 1)) ? 3'd0 : owner_q + 3'd1;

  // Arbitration next-state and shared lane transfer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    burst_d = burst_q;
    gnt_d   = gnt_q;
    valid_d = 1'b0;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          owner_d = scan_from(req, ptr_q);
          gnt_d   = onehot(owner_d);
          burst_d = 4'd1;
          state_d = StOwn;
        end else begin
          gnt_d = '0;
        end
      end
      StOwn: begin
        if (!own_req) begin
          // Release: hand over on the same edge, no transfer for the old owner.
          ptr_d = nxt;
          if (|others) begin
            owner_d = scan_from(others, nxt);
            gnt_d   = onehot(owner_d);
            burst_d = 4'd1;
          end else begin
            gnt_d   = '0;
            state_d = StIdle;
          end
        end else begin
          valid_d = 1'b1;
          data_d  = own_data;
          if (burst_q == 4'(MAX_BURST) && |others) begin
            owner_d = scan_from(others, nxt);
            gnt_d   = onehot(owner_d);
            ptr_d   = nxt;
            burst_d = 4'd1;
          end else if (burst_q < 4'(MAX_BURST)) begin
            burst_d = burst_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset clears any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      burst_q <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule
